// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects operand A, operand B and an opcode for alu_8bits
// over one shared byte bus, one item per synchronized load strobe, then latches
// the ALU result into a held output with a valid flag.
//
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   ena           - design enable; FSM and capture registers hold while low
//   din           - shared operand/opcode bus
//   load          - asynchronous level strobe from a pin; rising edge steps capture
//   clear         - synchronous flush of FSM and capture/result registers
//   alu_a/b/s     - registered operands and opcode presented to the ALU
//   alu_result    - combinational result returned by the ALU
//   result        - held result of the last completed operation
//   result_valid  - result holds a completed operation
//   phase         - current FSM state (0=WAIT_A, 1=WAIT_B, 2=WAIT_OP, 3=EXEC)
module alu_operand_loader #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OP_W        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  input  logic              clear,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [1:0]        phase
);

  // Fewer than two stages would not be a real synchronizer.
  localparam int unsigned SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    StWaitA  = 2'd0,
    StWaitB  = 2'd1,
    StWaitOp = 2'd2,
    StExec   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Load strobe synchronizer and rising-edge detector.
  // Free-running: neither ena nor clear touches it, so an edge seen while ena
  // is low is consumed and lost.
  // ---------------------------------------------------------------------------
  logic [SyncN-1:0] sync_q;
  logic             sync_prev_q;
  logic             sync_out;
  logic             load_pulse;

  assign sync_out   = sync_q[SyncN-1];
  assign load_pulse = sync_out & ~sync_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SyncN-2:0], load};
      sync_prev_q <= sync_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   s_q, s_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    result_d = result_q;
    valid_d  = valid_q;

    if (clear) begin
      // Flush wins over a pending capture and over EXEC.
      state_d  = StWaitA;
      a_d      = '0;
      b_d      = '0;
      s_d      = '0;
      result_d = '0;
      valid_d  = 1'b0;
    end else if (ena) begin
      unique case (state_q)
        StWaitA: begin
          if (load_pulse) begin
            a_d     = din;
            valid_d = 1'b0;  // old result stays visible but is no longer current
            state_d = StWaitB;
          end
        end
        StWaitB: begin
          if (load_pulse) begin
            b_d     = din;
            state_d = StWaitOp;
          end
        end
        StWaitOp: begin
          if (load_pulse) begin
            s_d     = din[OP_W-1:0];
            state_d = StExec;
          end
        end
        StExec: begin
          // Operands have been stable for a full cycle; sample the ALU.
          result_d = alu_result;
          valid_d  = 1'b1;
          state_d  = StWaitA;
        end
        default: state_d = StWaitA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StWaitA;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_s        = s_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign phase        = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a stub ALU.
module tb_alu_operand_loader;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;
  logic       load;
  logic       clear;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_s;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       result_valid;
  logic [1:0] phase;

  alu_operand_loader #(
    .DATA_W     (8),
    .OP_W       (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .din         (din),
    .load        (load),
    .clear       (clear),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_result  (alu_result),
    .result      (result),
    .result_valid(result_valid),
    .phase       (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic shared by the stub ALU and the expectation model.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] s);
    case (s)
      2'd0:    ref_alu = 8'((int'(a) + int'(b)) % 256);
      2'd1:    ref_alu = a ^ b;
      2'd2:    ref_alu = a & b;
      default: ref_alu = a | b;
    endcase
  endfunction

  always_comb alu_result = ref_alu(alu_a, alu_b, alu_s);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: which item is expected next, and what is held.
  int         exp_k;
  logic [7:0] exp_a, exp_b, exp_res;
  logic [1:0] exp_s;
  logic       exp_valid;
  bit         exec_pending;
  logic [7:0] sb[$];

  task automatic model_clear();
    exp_k = 0; exp_a = 0; exp_b = 0; exp_s = 0; exp_res = 0; exp_valid = 0;
    exec_pending = 0;
  endtask

  task automatic model_accept(input logic [7:0] d);
    if (exp_k == 0) begin
      exp_a = d; exp_valid = 0; exp_k = 1;
    end else if (exp_k == 1) begin
      exp_b = d; exp_k = 2;
    end else begin
      exp_s   = d[1:0];
      exp_res = ref_alu(exp_a, exp_b, exp_s);
      sb.push_back(exp_res);
      exp_valid    = 1;
      exp_k        = 0;
      exec_pending = 1;
    end
  endtask

  // Monitor: every new completed result is popped from the scoreboard.
  logic vprev;
  always @(negedge clk) begin
    if (!rst_n) begin
      vprev <= 1'b0;
    end else begin
      if (result_valid && !vprev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: result 0x%0h with nothing expected", result);
        end else begin
          check("sb_result", result, sb.pop_front());
        end
      end
      vprev <= result_valid;
    end
  end

  // One full strobe: rise, capture (3 edges), release and drain the synchronizer.
  task automatic do_load(input logic [7:0] d);
    din  = d;
    load = 1'b1;
    tick(3);
    model_accept(d);
    check("phase_cap", phase, exec_pending ? 3 : exp_k);
    check("alu_a", alu_a, exp_a);
    check("alu_b", alu_b, exp_b);
    check("alu_s", alu_s, exp_s);
    load = 1'b0;
    tick(3);
    exec_pending = 0;
    check("phase_idle", phase, exp_k);
    check("result", result, exp_res);
    check("result_valid", result_valid, exp_valid);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_a"}, alu_a, 0);
    check({tag, "_b"}, alu_b, 0);
    check({tag, "_s"}, alu_s, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_valid"}, result_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; din = 8'h00; load = 1'b0; clear = 1'b0;
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Basic add with explicit latency checks on the opcode load.
    do_load(8'h12);
    do_load(8'h34);
    din = 8'h00; load = 1'b1;
    tick(2);
    check("lat_pre_phase", phase, 2);
    tick(1);
    model_accept(8'h00);
    check("lat_exec_phase", phase, 3);
    check("lat_exec_valid", result_valid, 0);
    tick(1);
    check("lat_valid", result_valid, 1);
    check("lat_result", result, 8'h46);
    check("lat_phase", phase, 0);
    load = 1'b0;
    tick(3);
    exec_pending = 0;

    // Opcode masking and XOR, then a new A drops valid but keeps result.
    do_load(8'hF0);
    do_load(8'h0F);
    do_load(8'hFD);
    check("xor_s", alu_s, 1);
    check("xor_result", result, 8'hFF);
    do_load(8'hAA);
    check("newa_valid", result_valid, 0);
    check("newa_result", result, 8'hFF);

    // Held strobe: one capture only, 3-cycle latency.
    clear = 1'b1; tick(1); clear = 1'b0; model_clear();
    check_all_zero("clear1");
    din = 8'h55; load = 1'b1;
    tick(2);
    check("held_early", alu_a, 0);
    tick(1);
    check("held_lat", alu_a, 8'h55);
    model_accept(8'h55);
    tick(17);
    check("held_phase", phase, 1);
    check("held_b", alu_b, 0);
    load = 1'b0;
    tick(3);

    // clear beats a load pulse in WAIT_OP.
    do_load(8'h11);
    do_load(8'h22);
    din = 8'h03; load = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_clear();
    check_all_zero("clr_prio");
    tick(1);
    check("clr_no_exec", phase, 0);
    load = 1'b0;
    tick(3);

    // clear while a result is valid.
    do_load(8'h21);
    do_load(8'h43);
    do_load(8'h00);
    check("pre_clr_valid", result_valid, 1);
    clear = 1'b1; tick(1); clear = 1'b0; model_clear();
    check("clr_valid", result_valid, 0);
    check("clr_result", result, 0);

    // Edge while ena is low is lost.
    ena = 1'b0; din = 8'h77; load = 1'b1;
    tick(4);
    ena = 1'b1;
    tick(4);
    check("ena_lost_phase", phase, 0);
    check("ena_lost_a", alu_a, 0);
    load = 1'b0;
    tick(3);

    // ena low while in EXEC holds the FSM there.
    do_load(8'h40);
    do_load(8'h05);
    din = 8'h01; load = 1'b1;
    tick(3);
    model_accept(8'h01);
    check("ena_exec_phase", phase, 3);
    ena = 1'b0;
    tick(2);
    load = 1'b0;
    tick(3);
    check("ena_hold_phase", phase, 3);
    check("ena_hold_valid", result_valid, 0);
    ena = 1'b1;
    tick(1);
    exec_pending = 0;
    check("ena_resume_phase", phase, 0);
    check("ena_resume_result", result, 8'h45);
    check("ena_resume_valid", result_valid, 1);
    tick(2);

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      do_load(8'($urandom));
      do_load(8'($urandom));
      do_load(8'($urandom));
      tick($urandom_range(0, 3));
    end

    // Asynchronous reset mid-sequence.
    do_load(8'h9A);
    do_load(8'hBC);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    do_load(8'h07);
    do_load(8'h08);
    do_load(8'h00);
    check("post_rst_result", result, 8'h0F);

    tick(2);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream operand sequencer for alu_8bits. The ALU needs A, B and an opcode, but all three must arrive over the single 8-bit ui_in bus, so this block captures them one at a time. A synchronized load strobe steps the capture, the block presents the registered operands to the ALU, and it latches the ALU result into a held output with a valid flag. It sits between the top-level pin wrapper and alu_8bits.

Parameters:
DATA_W, 8, operand and result width
OP_W, 2, opcode width; opcode is din[OP_W-1:0]
SYNC_STAGES, 2, flops in the load-strobe synchronizer (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; when low, the FSM and capture registers hold
din  input  DATA_W  shared operand/opcode bus (ui_in)
load  input  1  asynchronous capture strobe from a pin; level input
clear  input  1  synchronous abort/flush, active-high
alu_a  output  DATA_W  operand A to alu_8bits
alu_b  output  DATA_W  operand B to alu_8bits
alu_s  output  OP_W  opcode to alu_8bits
alu_result  input  DATA_W  combinational result from alu_8bits
result  output  DATA_W  held result
result_valid  output  1  result holds a completed operation
phase  output  2  current FSM state (debug)

Behaviour:
- Reset: while rst_n is low, everything clears immediately: all outputs, the a/b/s/result registers, the synchronizer and edge-detect flops, result_valid and phase. Reset asynchronously forces the FSM to WAIT_A (phase=0).
- Load strobe path:
  - load passes through SYNC_STAGES flops, then a rising-edge detector.
  - load_pulse is high for exactly one cycle when the synchronizer output is 1 and its previous value was 0.
  - Latency: with load rising before clk edge 0, load_pulse is high in cycle SYNC_STAGES, and the capture is visible at cycle SYNC_STAGES+1.
  - Holding load high produces exactly one pulse.
  - The synchronizer and edge detector keep running while ena is low, so an edge that occurs while ena is low is lost.
- FSM (phase encoding):
  - WAIT_A=0: on load_pulse&ena, a_reg<=din, result_valid<=0, go to WAIT_B.
  - WAIT_B=1: on load_pulse&ena, b_reg<=din, go to WAIT_OP.
  - WAIT_OP=2: on load_pulse&ena, s_reg<=din[OP_W-1:0] (upper bits ignored), go to EXEC.
  - EXEC=3: unconditional single cycle (still gated by ena). result<=alu_result, result_valid<=1, go to WAIT_A.
  - load_pulse during EXEC is ignored.
- alu_a/alu_b/alu_s are driven directly from a_reg/b_reg/s_reg; they are stable from capture through EXEC.
- End-to-end latency: result_valid rises 2 cycles after the load_pulse that captures the opcode.
- result and result_valid hold until the next A capture (result_valid drops; result keeps its old value) or until clear.
- clear has priority over load_pulse and over EXEC. When clear=1 at a clock edge:
  - phase becomes 0;
  - a_reg, b_reg, s_reg, result and result_valid become 0;
  - the synchronizer is not cleared.
- ena=0: FSM, capture registers and result hold. If the FSM is in EXEC, it stays there until ena returns; then result is sampled.
- Reset mid-sequence: partial operands are discarded and the next load captures A.

Test Plan:
Bench stub ALU: alu_result = alu_a + alu_b (mod 256) when S=0, alu_a ^ alu_b when S=1. SYNC_STAGES=2.
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 and phase=0 immediately, without waiting for a clock edge.
- Basic sequence: load pulses with din=0x12, 0x34, 0x00 -> alu_a=0x12, alu_b=0x34, alu_s=0; result=0x46 and result_valid=1 exactly 2 cycles after the third load_pulse.
- Opcode masking and XOR: din=0xF0, 0x0F, 0xFD (low bits 01) -> alu_s=1, result=0xFF. Then a fourth load with din=0xAA -> result_valid=0, alu_a=0xAA, result stays 0xFF.
- Held strobe: load high for 20 cycles with din=0x55 -> only A is captured, phase=1. Also check load_pulse latency: 3 cycles from load rise to alu_a=0x55.
- clear priority: clear=1 in the same cycle as a load_pulse in WAIT_OP -> phase=0, all registers 0, no EXEC. Also clear while result_valid=1 -> result_valid=0.
- ena gating: ena=0 while a load edge occurs -> no capture and the edge is lost. ena=0 while in EXEC -> phase stays 3; when ena returns, result=alu_result and phase=0.
